axis_gemv_fixed_acc_out: RTL and testbench

Output stage of the fixed-point GEMV datapath: consumes the stream of 50-bit signed products from the 25x25 signed multiplier, accumulates one dot product per matrix row, and requantizes each sum back to the 25-bit fixed-point format. The result is transmitted as a sign-extended 32-bit AXI4-Stream beat. It is the transmit end of the datapath, sitting between the multiplier and the `m_axis` output port of `axis_gemv_fixed`.

---
 rtl/axis_gemv_fixed_pkg.sv | 31 +++
 rtl/axis_gemv_fixed_requant.sv | 62 ++++++
 rtl/axis_gemv_fixed_acc_out.sv | 144 ++++++++++++++
 tb/tb_axis_gemv_fixed_acc_out.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_gemv_fixed_pkg.sv
// Shared widths, types and FSM encoding for the fixed-point GEMV output stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Products arrive as Q2.48 (50-bit signed), are summed in a 58-bit accumulator
// (8 guard bits) and leave as Q1.24 (25-bit signed) inside a 32-bit AXIS beat.
package axis_gemv_fixed_pkg;

  localparam int GEMV_PROD_W     = 50;
  localparam int GEMV_ACC_W      = 58;
  localparam int GEMV_FRAC_SHIFT = 24;
  localparam int GEMV_OUT_W      = 25;
  localparam int GEMV_ROWS       = 16;
  localparam int GEMV_AXIS_W     = 32;

  typedef logic signed [GEMV_PROD_W-1:0] prod_t;
  typedef logic signed [GEMV_ACC_W-1:0]  acc_t;
  typedef logic signed [GEMV_OUT_W-1:0]  out_t;

  // ST_ACC: no result held; ST_HOLD: a requantized result is on m_axis.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Sign-extend a product into the accumulator width.
  function automatic acc_t sext_prod(input prod_t p);
    return {{(GEMV_ACC_W-GEMV_PROD_W){p[GEMV_PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/axis_gemv_fixed_requant.sv
// Round/shift/clamp of a finished dot product from Q2.48 to Q1.24.
// Latency: combinational.
// Backpressure: none (pure function of the input).
//
// Ports:
//   sum  - accumulated row sum (acc_t)
//   res  - requantized result (out_t)
//   sat  - high when res was clamped (only with GEMV_ACC_SAT_EN)
// Macro GEMV_ACC_SAT_EN: defined -> clamp to the out_t range and flag it;
//                        undefined -> keep the low OUT_W bits (wrap-around).
module axis_gemv_fixed_requant
  import axis_gemv_fixed_pkg::*;
(
  input  acc_t sum,
  output out_t res,
  output logic sat
);

  // Width of the shifted value before narrowing to out_t.
  localparam int RW = GEMV_ACC_W + 1 - GEMV_FRAC_SHIFT;

  localparam logic signed [GEMV_ACC_W:0] HALF =
    {{GEMV_ACC_W{1'b0}}, 1'b1} << (GEMV_FRAC_SHIFT - 1);

  localparam logic signed [RW-1:0] R_MAX =
    {{(RW-GEMV_OUT_W+1){1'b0}}, {(GEMV_OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] R_MIN =
    {{(RW-GEMV_OUT_W+1){1'b1}}, {(GEMV_OUT_W-1){1'b0}}};

  logic signed [GEMV_ACC_W:0] rnd;
  logic signed [RW-1:0]       r;
  logic                       unused_frac;

  // One extra bit so adding the half-LSB can never overflow; taking the
  // upper slice is the arithmetic right shift (round half toward +inf).
  assign rnd = $signed({sum[GEMV_ACC_W-1], sum}) + HALF;
  assign r   = rnd[GEMV_ACC_W:GEMV_FRAC_SHIFT];

  // Fraction bits are consumed by the rounding add only.
  assign unused_frac = ^rnd[GEMV_FRAC_SHIFT-1:0];

`ifdef GEMV_ACC_SAT_EN
  always_comb begin
    res = r[GEMV_OUT_W-1:0];
    sat = 1'b0;
    if (r > R_MAX) begin
      res = R_MAX[GEMV_OUT_W-1:0];
      sat = 1'b1;
    end else if (r < R_MIN) begin
      res = R_MIN[GEMV_OUT_W-1:0];
      sat = 1'b1;
    end
  end
`else
  logic unused_hi;

  assign res       = r[GEMV_OUT_W-1:0];
  assign sat       = 1'b0;
  assign unused_hi = ^{r[RW-1:GEMV_OUT_W], R_MAX, R_MIN};
`endif

endmodule

// File: rtl/axis_gemv_fixed_acc_out.sv
// Accumulates products per matrix row, requantizes each sum and sends it on m_axis.
// Latency: m_axis_tvalid rises one cycle after the accepted s_prod_tlast beat.
// Backpressure: s_prod_tready = !m_axis_tvalid || m_axis_tready; full rate while m_axis_tready=1.
//
// Ports:
//   ap_clk, ap_rst         - clock, asynchronous active-high reset
//   s_prod_*               - product stream in (tdata/tvalid/tready/tlast)
//   m_axis_*               - sign-extended 32-bit result stream out, tlast on row ROWS-1
//   sat_seen               - sticky saturation flag
// Macro GEMV_ACC_SAT_EN: enables clamping and sat_seen; otherwise results wrap and
// sat_seen is tied low.
module axis_gemv_fixed_acc_out
  import axis_gemv_fixed_pkg::*;
#(
  parameter int PROD_W     = GEMV_PROD_W,
  parameter int ACC_W      = GEMV_ACC_W,
  parameter int FRAC_SHIFT = GEMV_FRAC_SHIFT,
  parameter int OUT_W      = GEMV_OUT_W,
  parameter int ROWS       = GEMV_ROWS
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] s_prod_tdata,
  input  logic              s_prod_tvalid,
  output logic              s_prod_tready,
  input  logic              s_prod_tlast,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              sat_seen
);

  localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  // The datapath types come from the package; a mismatched override would
  // silently truncate, so refuse to elaborate instead.
  if (PROD_W != GEMV_PROD_W || ACC_W != GEMV_ACC_W ||
      FRAC_SHIFT != GEMV_FRAC_SHIFT || OUT_W != GEMV_OUT_W) begin : g_bad_cfg
    $error("axis_gemv_fixed_acc_out: width parameters must match axis_gemv_fixed_pkg");
  end

  state_t          state;
  acc_t            acc;
  acc_t            sum;
  out_t            out_q;
  out_t            rq_res;
  logic            rq_sat;
  logic [RC_W-1:0] row_cnt;

  logic beat_acc;
  logic row_done;
  logic out_hs;

  assign s_prod_tready = !m_axis_tvalid || m_axis_tready;
  assign beat_acc      = s_prod_tvalid && s_prod_tready;
  assign row_done      = beat_acc && s_prod_tlast;
  assign out_hs        = m_axis_tvalid && m_axis_tready;

  // Sum including the current beat; this is what gets requantized on tlast.
  assign sum = acc + sext_prod(prod_t'(s_prod_tdata));

  axis_gemv_fixed_requant u_requant (
    .sum (sum),
    .res (rq_res),
    .sat (rq_sat)
  );

  // Control FSM; m_axis_tvalid is registered alongside the state.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state         <= ST_ACC;
      m_axis_tvalid <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (row_done) begin
            state         <= ST_HOLD;
            m_axis_tvalid <= 1'b1;
          end
        end
        ST_HOLD: begin
          // A row can only finish here when the held result is being taken,
          // so staying in HOLD means the new result replaces the old one.
          if (out_hs && !row_done) begin
            state         <= ST_ACC;
            m_axis_tvalid <= 1'b0;
          end
        end
        default: begin
          state         <= ST_ACC;
          m_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

  // Accumulator and output register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc   <= '0;
      out_q <= '0;
    end else begin
      if (beat_acc) begin
        acc <= row_done ? acc_t'(0) : sum;
      end
      if (row_done) begin
        out_q <= rq_res;
      end
    end
  end

  // Row counter advances per delivered result, wrapping at the frame size.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      row_cnt <= '0;
    end else if (out_hs) begin
      if (row_cnt == RC_W'(ROWS - 1)) begin
        row_cnt <= '0;
      end else begin
        row_cnt <= row_cnt + RC_W'(1);
      end
    end
  end

`ifdef GEMV_ACC_SAT_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      sat_seen <= 1'b0;
    end else if (row_done && rq_sat) begin
      sat_seen <= 1'b1;
    end
  end
`else
  logic unused_sat;

  assign unused_sat = rq_sat;
  assign sat_seen   = 1'b0;
`endif

  assign m_axis_tdata = {{(32-OUT_W){out_q[OUT_W-1]}}, out_q};
  assign m_axis_tlast = (row_cnt == RC_W'(ROWS - 1));

endmodule

// File: tb/tb_axis_gemv_fixed_acc_out.sv
module tb_axis_gemv_fixed_acc_out;

`ifdef GEMV_ACC_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic        ap_clk;
  logic        ap_rst;
  logic [49:0] s_tdata;
  logic        s_tvalid;
  logic        s_prod_tready;
  logic        s_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_rdy;
  logic        m_axis_tlast;
  logic        sat_seen;

  axis_gemv_fixed_acc_out dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .s_prod_tdata  (s_tdata),
    .s_prod_tvalid (s_tvalid),
    .s_prod_tready (s_prod_tready),
    .s_prod_tlast  (s_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_rdy),
    .m_axis_tlast  (m_axis_tlast),
    .sat_seen      (sat_seen)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  logic sat_model = 1'b0;

  typedef struct {
    logic [3:0][49:0] b;
    int               n;
    logic [31:0]      d_sat;
    logic             f_sat;
    logic [31:0]      d_trn;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int k, input int n,
                         input logic [49:0] b0, input logic [49:0] b1,
                         input logic [49:0] b2, input logic [49:0] b3,
                         input logic [31:0] dsat, input logic fsat,
                         input logic [31:0] dtrn);
    vt[k].n     = n;
    vt[k].b[0]  = b0;
    vt[k].b[1]  = b1;
    vt[k].b[2]  = b2;
    vt[k].b[3]  = b3;
    vt[k].d_sat = dsat;
    vt[k].f_sat = fsat;
    vt[k].d_trn = dtrn;
  endtask

  // Drives n beats starting at posedge+1, one per cycle when accepted;
  // returns at posedge+1 after the last accepted beat.
  task automatic send_row(input logic [3:0][49:0] b, input int n, input bit full,
                          input logic [31:0] ed, input logic ef);
    int   w;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      s_tdata  = b[i];
      s_tvalid = 1'b1;
      s_tlast  = full && (i == n - 1);
      @(negedge ap_clk);
      w = 0;
      while (!s_prod_tready && w < 200) begin
        @(negedge ap_clk);
        w++;
      end
      if (w >= 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL in_wait: s_prod_tready=0 for 200 cycles, want 1");
      end
      @(posedge ap_clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (full) begin
      sat_model = sat_model | ef;
      e.d   = ed;
      e.sat = sat_model;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(posedge ap_clk);
      w++;
    end
    if (w >= 500) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d results outstanding, want 0", sb.size());
    end
    repeat (2) @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst    = 1'b1;
    sat_model = 1'b0;
    @(negedge ap_clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_sat_seen", sat_seen, 0);
    chk("rst_s_tready", s_prod_tready, 1);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on each handshake, checks tlast from
  // its own row index and checks that a stalled beat does not change.
  int          out_idx = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;

  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst) begin
      out_idx    = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_tvalid", m_axis_tvalid, 1);
        chk("hold_tdata", m_axis_tdata, prev_d);
        chk("hold_tlast", m_axis_tlast, prev_l);
      end
      if (m_axis_tvalid && m_rdy) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got tdata %h, want no beat", m_axis_tdata);
        end else begin
          e = sb.pop_front();
          chk("out_tdata", m_axis_tdata, e.d);
          chk("out_tlast", m_axis_tlast, (out_idx % 16) == 15);
          chk("out_sat_seen", sat_seen, e.sat);
        end
        out_idx++;
      end
      stall_prev = m_axis_tvalid && !m_rdy;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][49:0] rb;
    logic [49:0]      v;
    time              t0;

    ap_rst   = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_rdy    = 1'b1;

    // Expected values: r = floor((sum + 2^23) / 2^24), then clamp or wrap to 25 bits.
    set_vec(0, 3, 50'h0_0100_0000_0000, 50'h0_0100_0000_0000, 50'h0_0100_0000_0000, '0,
            32'h0003_0000, 1'b0, 32'h0003_0000);                  // 3 * 2^40 -> 3*2^16
    set_vec(1, 1, 50'h0_0000_00C0_0000, '0, '0, '0, 32'h0000_0001, 1'b0, 32'h0000_0001);
    set_vec(2, 1, 50'h0_0000_007F_FFFF, '0, '0, '0, 32'h0000_0000, 1'b0, 32'h0000_0000);
    set_vec(3, 1, 50'h3_FFFF_FF80_0000, '0, '0, '0, 32'h0000_0000, 1'b0, 32'h0000_0000); // -0.5 LSB -> 0
    set_vec(4, 1, 50'h3_FFFF_FF7F_FFFF, '0, '0, '0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF); // just below -> -1
    set_vec(5, 1, 50'h0_FFFF_FF00_0000, '0, '0, '0, 32'h00FF_FFFF, 1'b0, 32'h00FF_FFFF); // max in range
    set_vec(6, 1, 50'h3_0000_0000_0000, '0, '0, '0, 32'hFF00_0000, 1'b0, 32'hFF00_0000); // min in range
    // 4 * 2^48 = 2^50 -> r = 2^26: clamps high, or wraps to 0.
    set_vec(7, 4, 50'h1_0000_0000_0000, 50'h1_0000_0000_0000, 50'h1_0000_0000_0000,
            50'h1_0000_0000_0000, 32'h00FF_FFFF, 1'b1, 32'h0000_0000);
    // -5 * 2^48 -> r = -5*2^24: clamps low; low 25 bits are 0x1000000 (also 0xFF000000).
    set_vec(8, 3, 50'h2_0000_0000_0000, 50'h2_0000_0000_0000, 50'h3_0000_0000_0000, '0,
            32'hFF00_0000, 1'b1, 32'hFF00_0000);

    do_reset();

    for (int k = 0; k < 9; k++) begin
      send_row(vt[k].b, vt[k].n, 1'b1,
               SAT_ON ? vt[k].d_sat : vt[k].d_trn,
               SAT_ON ? vt[k].f_sat : 1'b0);
    end
    drain();

    // Backpressure: result of row 1 is held for 10 cycles; row 2 must stall.
    m_rdy = 1'b0;
    rb    = '0;
    rb[0] = 50'h0_0100_0000_0000;
    rb[1] = 50'h0_0100_0000_0000;
    rb[2] = 50'h0_0100_0000_0000;
    send_row(rb, 3, 1'b1, 32'h0003_0000, 1'b0);
    fork
      begin
        logic [3:0][49:0] rb2;
        rb2    = '0;
        rb2[0] = 50'h3_FF00_0000_0000;
        rb2[1] = 50'h3_FF00_0000_0000;
        rb2[2] = 50'h3_FF00_0000_0000;
        send_row(rb2, 3, 1'b1, 32'hFFFD_0000, 1'b0);
      end
      begin
        repeat (10) begin
          @(negedge ap_clk);
          chk("bp_s_tready", s_prod_tready, 0);
          chk("bp_tvalid", m_axis_tvalid, 1);
        end
        @(posedge ap_clk);
        #1;
        m_rdy = 1'b1;
      end
    join
    drain();

    // Reset mid-row: partial sum must vanish and produce no beat.
    rb    = '0;
    rb[0] = 50'h0_0400_0000_0000;
    rb[1] = 50'h0_0400_0000_0000;
    send_row(rb, 2, 1'b0, 32'h0, 1'b0);
    do_reset();
    rb    = '0;
    rb[0] = 50'h1_0000_0000_0000;   // 1.0: r = 2^24, one above max
    send_row(rb, 1, 1'b1, SAT_ON ? 32'h00FF_FFFF : 32'hFF00_0000, SAT_ON);
    drain();

    // Frame wrap: 17 back-to-back rows of 3 beats; tlast only on the 16th.
    do_reset();
    t0 = $time;
    for (int i = 0; i < 17; i++) begin
      v     = 50'(i + 1);
      v     = v << 24;
      rb    = '0;
      rb[0] = v;
      rb[1] = v;
      rb[2] = v;
      send_row(rb, 3, 1'b1, 32'(3 * (i + 1)), 1'b0);
    end
    chk("frame_cycles", ($time - t0) / 10, 51);
    drain();
    chk("frame_outputs", out_idx, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
